// File: rtl/sync_data_fifo_pkg.sv
// Shared defaults and helpers for the single-clock data FIFO.
// Default geometry matches the 64-bit x 128 bridge FIFO it replaces.
package sync_data_fifo_pkg;

    localparam int DATA_W_DEF    = 64;
    localparam int ADDR_W_DEF    = 7;
    localparam int AFULL_TH_DEF  = 120;
    localparam int AEMPTY_TH_DEF = 8;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    // Pointers and count carry one extra bit so a full FIFO is distinguishable from empty.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic bit th_ok(input int aempty_th, input int afull_th, input int addr_w);
        return (aempty_th < afull_th) && (afull_th <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/sync_data_fifo_if.sv
// Handshake and status bundle between the FIFO and its single-clock user.
// master = the side that pushes/pops, slave = the FIFO itself.
interface sync_data_fifo_if
    import sync_data_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic                      flush;
    logic [DATA_W-1:0]         data_in;
    logic                      write_en;
    logic                      read_en;
    logic [DATA_W-1:0]         data_out;
    logic                      data_valid;
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic                      almost_empty;
    logic [cnt_w(ADDR_W)-1:0]  count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output flush, data_in, write_en, read_en,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, data_in, write_en, read_en,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_data_fifo_sdp_ram.sv
// Simple dual-port storage, one write and one read port, no reset.
// Offers a combinational read (fall-through mode) and a registered read (one-cycle mode).
module sync_data_fifo_sdp_ram
    import sync_data_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_async_o,
    output logic [DATA_W-1:0] rdata_q_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a pop and push to the same slot (full FIFO) returns the old word.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q_o <= mem_q[raddr_i];
        end
    end

    assign rdata_async_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_data_fifo.sv
// Single-clock parametrised data FIFO: pointers, occupancy, thresholds,
// sticky error flags, synchronous flush and selectable read mode.
module sync_data_fifo
    import sync_data_fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AFULL_TH  = AFULL_TH_DEF,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF,
    parameter bit FWFT      = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    sync_data_fifo_if.slave bus
);

    localparam int               CNT_W = cnt_w(ADDR_W);
    localparam int               DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    if (!th_ok(AEMPTY_TH, AFULL_TH, ADDR_W)) begin : g_bad_th
        $error("sync_data_fifo: thresholds must satisfy AEMPTY_TH < AFULL_TH <= DEPTH");
    end

    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              empty_w, full_w;
    logic              rd_ok, wr_ok;
    logic              ram_we, ram_re;
    cnt_op_e           cnt_op;
    logic [DATA_W-1:0] rdata_async;
    logic [DATA_W-1:0] rdata_reg;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(DEPTH));

    // A push into a full FIFO is fine when a pop frees a slot in the same cycle.
    assign rd_ok  = bus.read_en && !empty_w;
    assign wr_ok  = bus.write_en && (!full_w || rd_ok);
    assign ram_we = wr_ok && !bus.flush;
    assign ram_re = rd_ok && !bus.flush;

    always_comb begin
        cnt_op = CNT_HOLD;
        if (wr_ok && !rd_ok) begin
            cnt_op = CNT_INC;
        end else if (rd_ok && !wr_ok) begin
            cnt_op = CNT_DEC;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (ram_we) begin
                wr_ptr_d = wr_ptr_q + ONE;
            end
            if (ram_re) begin
                rd_ptr_d = rd_ptr_q + ONE;
            end
            case (cnt_op)
                CNT_INC: count_d = count_q + ONE;
                CNT_DEC: count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (bus.write_en && !wr_ok);
            underflow_d = underflow_q | (bus.read_en && empty_w);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_data_fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk           (clk),
        .we_i          (ram_we),
        .waddr_i       (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i       (bus.data_in),
        .re_i          (ram_re),
        .raddr_i       (rd_ptr_q[ADDR_W-1:0]),
        .rdata_async_o (rdata_async),
        .rdata_q_o     (rdata_reg)
    );

    if (FWFT) begin : g_fwft
        logic [DATA_W-1:0] hold_q;
        logic              unused_rdata_reg;

        assign unused_rdata_reg = ^rdata_reg;

        // Remembers the last head word shown so data_out holds once the FIFO drains.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                hold_q <= '0;
            end else if (!empty_w) begin
                hold_q <= rdata_async;
            end
        end

        assign bus.data_out   = empty_w ? hold_q : rdata_async;
        assign bus.data_valid = !empty_w;
    end else begin : g_registered
        logic seen_q;
        logic valid_q;
        logic unused_rdata_async;

        assign unused_rdata_async = ^rdata_async;

        // The RAM read register has no reset; seen_q masks it to zero until the first pop.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                seen_q  <= 1'b0;
                valid_q <= 1'b0;
            end else if (bus.flush) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= ram_re;
                if (ram_re) begin
                    seen_q <= 1'b1;
                end
            end
        end

        assign bus.data_out   = seen_q ? rdata_reg : '0;
        assign bus.data_valid = valid_q;
    end

    assign bus.count        = count_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_full  = (count_q >= CNT_W'(AFULL_TH));
    assign bus.almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
